// File: rtl/raw10_unpacker.sv
// RAW10 unpacker: re-aligns 5-byte CSI-2 RAW10 groups from 4-byte payload words into 4 pixels.
// Optional RAW8_PASSTHROUGH_EN: data type 0x2A words bypass the buffer as 4 left-aligned pixels.
module raw10_unpacker #(
  parameter logic [5:0] RAW10_DATA_TYPE = 6'h2B
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0][7:0]  image_data_i,
  input  logic             image_data_enable_i,
  input  logic [5:0]       image_data_type_i,
  input  logic             packet_end_i,
  output logic [3:0][9:0]  pixel_data_o,
  output logic             pixel_enable_o,
  output logic             alignment_error_o
);

`ifdef RAW8_PASSTHROUGH_EN
  localparam logic [5:0] Raw8DataType = 6'h2A;
`endif

  // Byte 0 of the buffer is the oldest byte; unused upper bytes are kept at zero.
  logic [7:0][7:0] buf_q, buf_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0][9:0] pixel_q, pixel_d;
  logic            pix_en_q, pix_en_d;
  logic            err_q, err_d;

  logic            accept;
  logic [7:0][7:0] merged;
  logic [3:0]      merged_cnt;

  always_comb begin
    accept     = image_data_enable_i && (image_data_type_i == RAW10_DATA_TYPE);
    merged     = buf_q;
    merged_cnt = cnt_q;
    if (accept) begin
      merged     = buf_q | ({32'h0, image_data_i} << {cnt_q, 3'b000});
      merged_cnt = cnt_q + 4'd4;
    end

    buf_d    = merged;
    cnt_d    = merged_cnt;
    pixel_d  = pixel_q;
    pix_en_d = 1'b0;
    err_d    = 1'b0;

    if (merged_cnt >= 4'd5) begin
      for (int k = 0; k < 4; k++) begin
        pixel_d[k] = {merged[k], merged[4][2*k +: 2]};
      end
      buf_d    = merged >> 40;
      cnt_d    = merged_cnt - 4'd5;
      pix_en_d = 1'b1;
    end

`ifdef RAW8_PASSTHROUGH_EN
    if (image_data_enable_i && (image_data_type_i == Raw8DataType)) begin
      for (int k = 0; k < 4; k++) begin
        pixel_d[k] = {image_data_i[k], 2'b00};
      end
      pix_en_d = 1'b1;
    end
`endif

    // Flush sees the state after this cycle's word (and any emission) has been applied.
    if (packet_end_i) begin
      err_d = (cnt_d != 4'd0);
      cnt_d = 4'd0;
      buf_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q    <= '0;
      cnt_q    <= 4'd0;
      pixel_q  <= '0;
      pix_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      pixel_q  <= pixel_d;
      pix_en_q <= pix_en_d;
      err_q    <= err_d;
    end
  end

  assign pixel_data_o      = pixel_q;
  assign pixel_enable_o    = pix_en_q;
  assign alignment_error_o = err_q;

endmodule

// File: tb/tb_raw10_unpacker.sv
// Scoreboard bench for raw10_unpacker: byte-queue reference model feeds expected pixels/errors.
module tb_raw10_unpacker;

  logic            clk;
  logic            rst_n;
  logic [3:0][7:0] image_data;
  logic            image_data_enable;
  logic [5:0]      image_data_type;
  logic            packet_end;
  logic [3:0][9:0] pixel_data;
  logic            pixel_enable;
  logic            alignment_error;

  raw10_unpacker dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .image_data_i       (image_data),
    .image_data_enable_i(image_data_enable),
    .image_data_type_i  (image_data_type),
    .packet_end_i       (packet_end),
    .pixel_data_o       (pixel_data),
    .pixel_enable_o     (pixel_enable),
    .alignment_error_o  (alignment_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    int              when;
    logic [3:0][9:0] pix;
  } pix_exp_t;

  pix_exp_t        pix_q[$];
  int              err_q[$];
  logic [7:0]      model_bytes[$];
  logic [3:0][9:0] last_pix = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Reference model: bytes are a FIFO; every 5 bytes form a group unpacked into 4 pixels.
  function automatic void model_step(logic en, logic [5:0] dt, logic [3:0][7:0] d, logic pe);
    logic [7:0]      g[5];
    pix_exp_t        e;
    if (en && dt == 6'h2B) begin
      for (int i = 0; i < 4; i++) model_bytes.push_back(d[i]);
      if (model_bytes.size() >= 5) begin
        for (int i = 0; i < 5; i++) g[i] = model_bytes.pop_front();
        e.when = cyc + 1;
        for (int k = 0; k < 4; k++) e.pix[k] = {g[k], 2'b00} + 10'((g[4] >> (2 * k)) & 8'h3);
        pix_q.push_back(e);
      end
    end
`ifdef RAW8_PASSTHROUGH_EN
    if (en && dt == 6'h2A) begin
      e.when = cyc + 1;
      for (int k = 0; k < 4; k++) e.pix[k] = 10'(d[k]) * 10'd4;
      pix_q.push_back(e);
    end
`endif
    if (pe) begin
      if (model_bytes.size() != 0) err_q.push_back(cyc + 1);
      model_bytes.delete();
    end
  endfunction

  task automatic drive(logic en, logic [5:0] dt, logic [31:0] d, logic pe);
    @(posedge clk);
    #1;
    image_data_enable = en;
    image_data_type   = dt;
    image_data        = d;
    packet_end        = pe;
    model_step(en, dt, d, pe);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 6'h00, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n             = 1'b0;
    image_data_enable = 1'b0;
    packet_end        = 1'b0;
    #1;
    check("reset pixel_enable", 64'(pixel_enable), 64'd0);
    check("reset pixel_data", 64'(pixel_data), 64'd0);
    check("reset alignment_error", 64'(alignment_error), 64'd0);
    model_bytes.delete();
    pix_q.delete();
    err_q.delete();
    last_pix = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n) begin
      while (pix_q.size() != 0 && pix_q[0].when < cyc) begin
        check("missing pixel_enable", 64'd0, 64'(pix_q[0].when));
        void'(pix_q.pop_front());
      end
      if (pixel_enable) begin
        if (pix_q.size() == 0) begin
          check("unexpected pixel_enable", 64'(pixel_data), 64'hDEAD);
        end else begin
          check("pixel timing", 64'(cyc), 64'(pix_q[0].when));
          check("pixel data", 64'(pixel_data), 64'(pix_q[0].pix));
          last_pix = pix_q[0].pix;
          void'(pix_q.pop_front());
        end
      end else begin
        check("pixel hold", 64'(pixel_data), 64'(last_pix));
      end
      if (err_q.size() != 0 && err_q[0] == cyc) begin
        check("alignment_error", 64'(alignment_error), 64'd1);
        void'(err_q.pop_front());
      end else begin
        check("alignment_error idle", 64'(alignment_error), 64'd0);
      end
    end
  end

  logic [7:0]  grp[5];
  logic [7:0]  seq[20];
  logic [31:0] w;

  task automatic send_seq(logic pe_on_last);
    for (int i = 0; i < 5; i++) begin
      w = {seq[4*i+3], seq[4*i+2], seq[4*i+1], seq[4*i]};
      drive(1'b1, 6'h2B, w, pe_on_last && i == 4);
    end
    if (!pe_on_last) drive(1'b0, 6'h00, 32'h0, 1'b1);
  endtask

  initial begin
    rst_n             = 1'b0;
    image_data        = '0;
    image_data_enable = 1'b0;
    image_data_type   = '0;
    packet_end        = 1'b0;
    grp[0] = 8'h12; grp[1] = 8'h34; grp[2] = 8'h56; grp[3] = 8'h78; grp[4] = 8'hE4;
    for (int i = 0; i < 20; i++) seq[i] = grp[i % 5];
    #1;
    check("por pixel_enable", 64'(pixel_enable), 64'd0);
    check("por pixel_data", 64'(pixel_data), 64'd0);
    check("por alignment_error", 64'(alignment_error), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean 20-byte packet, separate packet_end.
    send_seq(1'b0);
    idle(2);
    // Single word then packet_end: partial group flagged.
    drive(1'b1, 6'h2B, 32'hAABBCCDD, 1'b0);
    drive(1'b0, 6'h00, 32'h0, 1'b1);
    idle(1);
    send_seq(1'b0);
    idle(2);
    // YUV words interleaved into a RAW10 stream.
    for (int i = 0; i < 5; i++) begin
      w = {seq[4*i+3], seq[4*i+2], seq[4*i+1], seq[4*i]};
      drive(1'b1, 6'h2B, w, 1'b0);
      drive(1'b1, 6'h18, $urandom, 1'b0);
    end
    drive(1'b0, 6'h00, 32'h0, 1'b1);
    idle(2);
    // Last word shares the cycle with packet_end (count 1 before it).
    send_seq(1'b1);
    idle(2);
    // Reset mid-packet with 3 bytes buffered, then a fresh packet.
    drive(1'b1, 6'h2B, 32'h01020304, 1'b0);
    drive(1'b1, 6'h2B, 32'h05060708, 1'b0);
    idle(1);
    do_reset();
    send_seq(1'b0);
    idle(2);
    // RAW8 word: pixels only when passthrough is built in.
    drive(1'b1, 6'h2A, 32'h018000FF, 1'b0);
    idle(2);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] dt;
      int unsigned r;
      r  = $urandom_range(0, 9);
      dt = (r < 6) ? 6'h2B : (r < 8) ? 6'h18 : 6'h2A;
      drive(1'($urandom_range(0, 3) != 0), dt, $urandom, 1'($urandom_range(0, 9) == 0));
    end
    drive(1'b0, 6'h00, 32'h0, 1'b1);
    idle(3);
    check("pixel queue drained", 64'(pix_q.size()), 64'd0);
    check("error queue drained", 64'(err_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
